// File: rtl/wb_writer_if.sv
// Writeback bus between the ALU/load sources, wb_writer and the register file.
// The slave modport is the wb_writer side; the master modport is the source/consumer side.
interface wb_writer_if #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
);
  logic                          alu_valid;
  logic [ADDRESS_WIDTH-1:0]      alu_rd;
  logic [DATA_WIDTH-1:0]         alu_data;
  logic                          ld_valid;
  logic                          ld_ready;
  logic [ADDRESS_WIDTH-1:0]      ld_rd;
  logic [DATA_WIDTH-1:0]         ld_data;
  logic                          wr_en;
  logic [ADDRESS_WIDTH-1:0]      wr_addr;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic [(2**ADDRESS_WIDTH)-1:0] pending;
  logic [$clog2(DEPTH):0]        fifo_count;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  ld_ready, wr_en, wr_addr, wr_data, pending, fifo_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output ld_ready, wr_en, wr_addr, wr_data, pending, fifo_count
  );
endinterface

// File: rtl/wb_writer.sv
// Register-file write port arbiter: ALU results write immediately, loads queue in a FIFO.
// Optional macro WB_LOAD_BYPASS_EN lets a load skip an empty FIFO when the ALU is idle.
module wb_writer #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_writer_if.slave  bus
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 2 ** ADDRESS_WIDTH;

  logic [DEPTH-1:0]         r_valid;
  logic [ADDRESS_WIDTH-1:0] r_rd   [DEPTH];
  logic [DATA_WIDTH-1:0]    r_data [DEPTH];
  logic [PW-1:0]            r_head;
  logic [PW-1:0]            r_tail;
  logic [CW-1:0]            r_count;

  logic                     r_wr_en;
  logic [ADDRESS_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0]    r_wr_data;

  logic                     w_alu_eff;
  logic                     w_empty;
  logic                     w_full;
  logic                     w_accept;
  logic                     w_bypass;
  logic                     w_pop;
  logic                     w_push;
  logic                     w_push_valid;
  logic [NREG-1:0]          w_pending;

  assign w_alu_eff    = bus.alu_valid && (bus.alu_rd != '0);
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == CW'(DEPTH));
  assign w_accept     = bus.ld_valid && !w_full;
  assign w_pop        = !w_alu_eff && !w_empty;

`ifdef WB_LOAD_BYPASS_EN
  assign w_bypass     = w_accept && w_empty && !w_alu_eff && (bus.ld_rd != '0);
`else
  assign w_bypass     = 1'b0;
`endif

  assign w_push       = w_accept && (bus.ld_rd != '0) && !w_bypass;
  // A load colliding with a same-cycle ALU write to the same rd is older, so it lands dead.
  assign w_push_valid = !(w_alu_eff && (bus.alu_rd == bus.ld_rd));

  always_comb begin
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i]) begin
        w_pending[r_rd[i]] = 1'b1;
      end
    end
    w_pending[0] = 1'b0;
  end

  // Kill, pop and push never touch the same slot in one cycle: tail only equals head when
  // the FIFO is empty (no pop) or full (no push). Popped slots are cleared so pending stays exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_alu_eff) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_rd[i] == bus.alu_rd) begin
            r_valid[i] <= 1'b0;
          end
        end
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      if (w_push) begin
        r_valid[r_tail] <= w_push_valid;
        r_rd[r_tail]    <= bus.ld_rd;
        r_data[r_tail]  <= bus.ld_data;
        r_tail          <= r_tail + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_alu_eff) begin
      r_wr_en   <= 1'b1;
      r_wr_addr <= bus.alu_rd;
      r_wr_data <= bus.alu_data;
    end else if (w_pop) begin
      r_wr_en   <= r_valid[r_head];
      r_wr_addr <= r_rd[r_head];
      r_wr_data <= r_data[r_head];
    end else if (w_bypass) begin
      r_wr_en   <= 1'b1;
      r_wr_addr <= bus.ld_rd;
      r_wr_data <= bus.ld_data;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  assign bus.ld_ready   = !w_full;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.pending    = w_pending;
  assign bus.fifo_count = r_count;
endmodule

// File: tb/tb_wb_writer.sv
// Testbench for wb_writer: directed scenarios plus randomized traffic against a queue-based model.
// Honours WB_LOAD_BYPASS_EN the same way the design does.
module tb_wb_writer;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int NREG  = 2 ** AW;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef struct {
    bit            valid;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } entry_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  entry_t        q[$];
  logic          exp_en   = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_data = '0;

  wb_writer_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  wb_writer #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [NREG-1:0] model_pending();
    logic [NREG-1:0] p;
    p = '0;
    foreach (q[i]) if (q[i].valid) p[q[i].rd] = 1'b1;
    return p;
  endfunction

  // Drives one cycle of requests and advances the reference model across the clock edge.
  task automatic drive(input bit av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                       input bit lv, input logic [AW-1:0] lrd, input logic [DW-1:0] ld,
                       output bit acc);
    bit     alu_eff;
    bit     byp;
    entry_t e;
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    bus.ld_valid  = lv;
    bus.ld_rd     = lrd;
    bus.ld_data   = ld;
    alu_eff = av && (ard != 0);
    acc     = lv && (q.size() != DEPTH);
    byp     = 1'b0;
`ifdef WB_LOAD_BYPASS_EN
    byp = acc && (q.size() == 0) && !alu_eff && (lrd != 0);
`endif
    @(posedge clk);
    if (alu_eff) begin
      exp_en = 1'b1; exp_addr = ard; exp_data = ad;
      foreach (q[i]) if (q[i].rd == ard) begin e = q[i]; e.valid = 1'b0; q[i] = e; end
    end else if (q.size() != 0) begin
      e = q.pop_front();
      exp_en = e.valid; exp_addr = e.rd; exp_data = e.data;
    end else if (byp) begin
      exp_en = 1'b1; exp_addr = lrd; exp_data = ld;
    end else begin
      exp_en = 1'b0;
    end
    if (acc && (lrd != 0) && !byp) begin
      e.valid = !(alu_eff && (ard == lrd));
      e.rd    = lrd;
      e.data  = ld;
      q.push_back(e);
    end
    #1;
  endtask

  task automatic idle();
    bit acc;
    drive(1'b0, '0, '0, 1'b0, '0, '0, acc);
  endtask

  task automatic test_reset();
    bit acc;
    #1;
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en: got %0h expected 0", bus.wr_en); end
    checks++; if (bus.wr_addr !== '0) begin errors++; $display("[TB] FAIL reset_wr_addr: got %0h expected 0", bus.wr_addr); end
    checks++; if (bus.wr_data !== '0) begin errors++; $display("[TB] FAIL reset_wr_data: got %0h expected 0", bus.wr_data); end
    checks++; if (bus.fifo_count !== '0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.fifo_count); end
    checks++; if (bus.pending !== '0) begin errors++; $display("[TB] FAIL reset_pending: got %0h expected 0", bus.pending); end
    checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ld_ready: got %0h expected 1", bus.ld_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    // Keep the ALU busy so three loads stay buffered, then pull reset mid-cycle.
    for (int k = 0; k < 3; k++) drive(1'b1, AW'(1), DW'(k), 1'b1, AW'(20 + k), DW'(32'h200 + k), acc);
    checks++; if (bus.fifo_count !== CW'(3)) begin errors++; $display("[TB] FAIL midreset_fill: got %0d expected 3", bus.fifo_count); end
    checks++; if (bus.pending !== NREG'(32'h0070_0000)) begin errors++; $display("[TB] FAIL midreset_pending: got %0h expected 700000", bus.pending); end
    bus.alu_valid = 1'b0; bus.ld_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL midreset_wr_en: got %0h expected 0", bus.wr_en); end
    checks++; if (bus.fifo_count !== '0) begin errors++; $display("[TB] FAIL midreset_count: got %0d expected 0", bus.fifo_count); end
    checks++; if (bus.pending !== '0) begin errors++; $display("[TB] FAIL midreset_pending_clr: got %0h expected 0", bus.pending); end
    checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ld_ready: got %0h expected 1", bus.ld_ready); end
    q.delete(); exp_en = 1'b0; exp_addr = '0; exp_data = '0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      idle();
      checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL postreset_no_write: got %0h expected 0", bus.wr_en); end
    end
  endtask

  task automatic test_alu_only();
    bit acc;
    drive(1'b1, AW'(5), 32'hDEAD_BEEF, 1'b0, '0, '0, acc);
    checks++; if (bus.wr_en !== 1'b1) begin errors++; $display("[TB] FAIL alu_wr_en: got %0h expected 1", bus.wr_en); end
    checks++; if (bus.wr_addr !== AW'(5)) begin errors++; $display("[TB] FAIL alu_wr_addr: got %0d expected 5", bus.wr_addr); end
    checks++; if (bus.wr_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL alu_wr_data: got %0h expected deadbeef", bus.wr_data); end
    drive(1'b1, AW'(0), 32'h1234_5678, 1'b0, '0, '0, acc);
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL alu_x0_wr_en: got %0h expected 0", bus.wr_en); end
    checks++; if (bus.wr_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL alu_x0_hold: got %0h expected deadbeef", bus.wr_data); end
  endtask

  task automatic test_load_latency();
    bit acc;
    drive(1'b0, '0, '0, 1'b1, AW'(7), 32'h11, acc);
`ifdef WB_LOAD_BYPASS_EN
    checks++; if (bus.wr_en !== 1'b1) begin errors++; $display("[TB] FAIL byp_wr_en: got %0h expected 1", bus.wr_en); end
    checks++; if (bus.wr_addr !== AW'(7)) begin errors++; $display("[TB] FAIL byp_wr_addr: got %0d expected 7", bus.wr_addr); end
    checks++; if (bus.wr_data !== 32'h11) begin errors++; $display("[TB] FAIL byp_wr_data: got %0h expected 11", bus.wr_data); end
    checks++; if (bus.fifo_count !== '0) begin errors++; $display("[TB] FAIL byp_count: got %0d expected 0", bus.fifo_count); end
    checks++; if (bus.pending !== '0) begin errors++; $display("[TB] FAIL byp_pending: got %0h expected 0", bus.pending); end
    idle();
`else
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL ld_n1_wr_en: got %0h expected 0", bus.wr_en); end
    checks++; if (bus.pending[7] !== 1'b1) begin errors++; $display("[TB] FAIL ld_n1_pending7: got %0h expected 1", bus.pending[7]); end
    checks++; if (bus.fifo_count !== CW'(1)) begin errors++; $display("[TB] FAIL ld_n1_count: got %0d expected 1", bus.fifo_count); end
    idle();
    checks++; if (bus.wr_en !== 1'b1) begin errors++; $display("[TB] FAIL ld_n2_wr_en: got %0h expected 1", bus.wr_en); end
    checks++; if (bus.wr_addr !== AW'(7)) begin errors++; $display("[TB] FAIL ld_n2_wr_addr: got %0d expected 7", bus.wr_addr); end
    checks++; if (bus.wr_data !== 32'h11) begin errors++; $display("[TB] FAIL ld_n2_wr_data: got %0h expected 11", bus.wr_data); end
    checks++; if (bus.pending[7] !== 1'b0) begin errors++; $display("[TB] FAIL ld_n2_pending7: got %0h expected 0", bus.pending[7]); end
`endif
  endtask

  task automatic test_full();
    bit            acc;
    bit            pend12;
    logic [AW-1:0] wlog[$];
    logic [AW-1:0] expseq [5];
    expseq = '{AW'(8), AW'(9), AW'(10), AW'(11), AW'(12)};
    pend12 = 1'b1;
    for (int k = 0; k < 4; k++) drive(1'b1, AW'(1 + k), DW'(k), 1'b1, AW'(8 + k), DW'(32'h100 + k), acc);
    checks++; if (bus.fifo_count !== CW'(4)) begin errors++; $display("[TB] FAIL full_count: got %0d expected 4", bus.fifo_count); end
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("[TB] FAIL full_ld_ready: got %0h expected 0", bus.ld_ready); end
    checks++; if (bus.pending !== NREG'(32'h0000_0F00)) begin errors++; $display("[TB] FAIL full_pending: got %0h expected f00", bus.pending); end
    drive(1'b1, AW'(1), DW'(4), 1'b1, AW'(12), 32'h10C, acc);
    checks++; if (bus.fifo_count !== CW'(4)) begin errors++; $display("[TB] FAIL full_hold_count: got %0d expected 4", bus.fifo_count); end
    for (int c = 0; c < 16; c++) begin
      drive(1'b0, '0, '0, pend12, AW'(12), 32'h10C, acc);
      if (acc) pend12 = 1'b0;
      if (bus.wr_en === 1'b1) wlog.push_back(bus.wr_addr);
    end
    checks++; if (wlog.size() != 5) begin errors++; $display("[TB] FAIL full_write_count: got %0d expected 5", wlog.size()); end
    for (int i = 0; i < 5 && i < wlog.size(); i++) begin
      checks++; if (wlog[i] !== expseq[i]) begin errors++; $display("[TB] FAIL full_order[%0d]: got %0d expected %0d", i, wlog[i], expseq[i]); end
    end
  endtask

  task automatic test_kill();
    bit acc;
    drive(1'b1, AW'(1), 32'h1, 1'b1, AW'(9), 32'hAA, acc);
    checks++; if (bus.pending[9] !== 1'b1) begin errors++; $display("[TB] FAIL kill_pending_set: got %0h expected 1", bus.pending[9]); end
    drive(1'b1, AW'(9), 32'hBB, 1'b0, '0, '0, acc);
    checks++; if (bus.pending[9] !== 1'b0) begin errors++; $display("[TB] FAIL kill_pending_clr: got %0h expected 0", bus.pending[9]); end
    checks++; if (bus.wr_data !== 32'hBB) begin errors++; $display("[TB] FAIL kill_alu_data: got %0h expected bb", bus.wr_data); end
    checks++; if (bus.fifo_count !== CW'(1)) begin errors++; $display("[TB] FAIL kill_slot_kept: got %0d expected 1", bus.fifo_count); end
    idle();
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL kill_pop_wr_en: got %0h expected 0", bus.wr_en); end
    checks++; if (bus.fifo_count !== '0) begin errors++; $display("[TB] FAIL kill_pop_count: got %0d expected 0", bus.fifo_count); end
  endtask

  task automatic test_collision();
    bit acc;
    drive(1'b1, AW'(3), 32'h33, 1'b1, AW'(3), 32'h44, acc);
    checks++; if (bus.wr_addr !== AW'(3) || bus.wr_data !== 32'h33) begin errors++; $display("[TB] FAIL coll_alu: got %0d/%0h expected 3/33", bus.wr_addr, bus.wr_data); end
    checks++; if (bus.fifo_count !== CW'(1)) begin errors++; $display("[TB] FAIL coll_count: got %0d expected 1", bus.fifo_count); end
    checks++; if (bus.pending[3] !== 1'b0) begin errors++; $display("[TB] FAIL coll_pending: got %0h expected 0", bus.pending[3]); end
    idle();
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL coll_dead_pop: got %0h expected 0", bus.wr_en); end
    drive(1'b0, '0, '0, 1'b1, AW'(0), 32'h55, acc);
    checks++; if (bus.fifo_count !== '0) begin errors++; $display("[TB] FAIL x0_load_count: got %0d expected 0", bus.fifo_count); end
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("[TB] FAIL x0_load_wr_en: got %0h expected 0", bus.wr_en); end
  endtask

  task automatic test_random();
    bit acc;
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 9) < 4, AW'($urandom_range(0, 15)), DW'($urandom),
            $urandom_range(0, 9) < 6, AW'($urandom_range(0, 15)), DW'($urandom), acc);
      checks++; if (bus.wr_en !== exp_en) begin errors++; $display("[TB] FAIL rand_wr_en c%0d: got %0h expected %0h", c, bus.wr_en, exp_en); end
      checks++; if (bus.wr_addr !== exp_addr) begin errors++; $display("[TB] FAIL rand_wr_addr c%0d: got %0d expected %0d", c, bus.wr_addr, exp_addr); end
      checks++; if (bus.wr_data !== exp_data) begin errors++; $display("[TB] FAIL rand_wr_data c%0d: got %0h expected %0h", c, bus.wr_data, exp_data); end
      checks++; if (bus.fifo_count !== CW'(q.size())) begin errors++; $display("[TB] FAIL rand_count c%0d: got %0d expected %0d", c, bus.fifo_count, q.size()); end
      checks++; if (bus.pending !== model_pending()) begin errors++; $display("[TB] FAIL rand_pending c%0d: got %0h expected %0h", c, bus.pending, model_pending()); end
      checks++; if (bus.ld_ready !== (q.size() != DEPTH)) begin errors++; $display("[TB] FAIL rand_ld_ready c%0d: got %0h expected %0h", c, bus.ld_ready, q.size() != DEPTH); end
    end
  endtask

  initial begin
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_data  = '0;
    test_reset();
    test_alu_only();
    test_load_latency();
    test_full();
    test_kill();
    test_collision();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_writer.md
Name: wb_writer

Overview:
- Write-side companion to the register file: owns the file's single write port (wr_en/wr_addr/wr_data) and arbitrates two writeback sources.
- ALU results are written immediately. Load results are buffered in a small FIFO and drained when the ALU is idle.
- Enforces x0 suppression and program-order correctness (a younger ALU write kills older buffered loads to the same rd).
- Exports a pending-register mask for decode stall logic.

Parameters:
ADDRESS_WIDTH, 5, register index width; register count = 2**ADDRESS_WIDTH
DATA_WIDTH, 32, register data width
DEPTH, 4, load FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU writeback request; always accepted, no ready
alu_rd  in  ADDRESS_WIDTH  ALU destination register
alu_data  in  DATA_WIDTH  ALU result
ld_valid  in  1  load writeback request
ld_ready  out  1  load request accepted when ld_valid && ld_ready
ld_rd  in  ADDRESS_WIDTH  load destination register
ld_data  in  DATA_WIDTH  load data
wr_en  out  1  register file write enable (registered)
wr_addr  out  ADDRESS_WIDTH  register file write address (registered)
wr_data  out  DATA_WIDTH  register file write data (registered)
pending  out  2**ADDRESS_WIDTH  bit r set = valid buffered load targets r
fifo_count  out  $clog2(DEPTH)+1  occupied FIFO slots, valid and killed

Behaviour:
- Reset (async, rst_n=0): wr_en=0, wr_addr=0, wr_data=0, FIFO empty, fifo_count=0, pending=0, ld_ready=1. Takes effect mid-operation immediately; all buffered loads are discarded.
- ld_ready = (fifo_count != DEPTH). It is combinational from state and independent of ld_valid/alu_valid.
- Each FIFO entry holds {valid, rd, data}. A push stores valid=1.
- Per cycle, in priority order, the selected action is registered onto wr_* at the next edge:
  1. alu_valid && alu_rd!=0: wr_en=1, wr_addr=alu_rd, wr_data=alu_data. The FIFO is not popped.
  2. Otherwise, FIFO non-empty: pop the head. wr_en = head.valid, wr_addr=head.rd, wr_data=head.data. A killed head is consumed with wr_en=0.
  3. Otherwise: wr_en=0. wr_addr/wr_data hold their previous values.
- Latency:
  - ALU request in cycle N: write visible on wr_* in N+1.
  - Load accepted in cycle N with an empty FIFO and no ALU traffic: enters FIFO at edge N, popped in N+1, visible on wr_* in N+2.
- x0:
  - alu_valid with alu_rd=0 is treated as no request (falls through to the pop).
  - An accepted load with ld_rd=0 is consumed (handshake completes) but not pushed.
  - pending[0] is always 0.
- Kill rule: when alu_valid && alu_rd!=0, every valid FIFO entry with rd==alu_rd has valid cleared at that edge. Killed entries still occupy a slot until popped.
- Simultaneous ALU and load push to the same rd in the same cycle: the load is older. It is accepted (handshake completes) but pushed with valid=0.
- Push and pop in the same cycle: both occur; fifo_count is unchanged. This applies when full too, but ld_ready=0 when full, so no push occurs.
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- pending: combinational OR over valid entries of the one-hot of rd. The entry being popped this cycle is still counted this cycle.

Optional Feature:
- Macro WB_LOAD_BYPASS_EN.
- Defined: a load accepted in cycle N with FIFO empty, no effective ALU request, and ld_rd!=0 skips the FIFO and is written to wr_* at edge N (visible N+1). fifo_count and pending are unaffected.
- Undefined: all loads go through the FIFO (N+2 minimum latency).
- All other rules are identical in both builds.

Test Plan:
- Reset mid-traffic: fill 3 loads, assert rst_n=0 -> wr_en=0, fifo_count=0, pending=0, ld_ready=1 immediately; no writes after release.
- ALU only: alu_valid rd=5 data=0xDEADBEEF in cycle N -> wr_en=1, wr_addr=5, wr_data=0xDEADBEEF in N+1; rd=0 request -> wr_en=0.
- Load latency: load rd=7 data=0x11 with FIFO empty, ALU idle -> write in N+2 (N+1 with WB_LOAD_BYPASS_EN); pending[7]=1 from N+1 to N+2 (non-bypass).
- Full/backpressure: hold alu_valid to rd 1..4 every cycle while pushing 5 loads to rd 8..12 -> ld_ready=0 after 4 accepted, fifo_count=4; drop alu_valid -> loads written in order rd 8,9,10,11, then rd 12.
- Kill: buffer load rd=9 data=0xAA, then ALU rd=9 data=0xBB while ALU busy -> pending[9] clears next edge, final write rd=9 data=0xBB only; the killed pop shows wr_en=0 for one cycle.
- Same-cycle collision: ALU and load both rd=3 in cycle N -> ALU value written N+1, load entry killed, never written; ld_rd=0 load consumed with no push.
